// File: rtl/wbu_pkg.sv
// Shared types and helpers for the write-back unit.
// Holds the rd source select encoding and the register address range check.
package wbu_pkg;

   typedef enum logic [1:0] {
      RD_SEL_ALU  = 2'b00,
      RD_SEL_LSU  = 2'b01,
      RD_SEL_CSR  = 2'b10,
      RD_SEL_LINK = 2'b11
   } rd_sel_t;

   localparam int REG_ADDR_W = 5;

   // True when a 5-bit register address names an implemented register.
   function automatic logic reg_in_range(input logic [REG_ADDR_W-1:0] addr, input int nr_reg);
      return int'(addr) < nr_reg;
   endfunction

endpackage

// File: rtl/regfile_nr.sv
// Architectural register file: one write port, two asynchronous read ports.
// x0 and unimplemented addresses always read as zero and are never written.
module regfile_nr
   import wbu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NR_REG = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [XLEN-1:0]       rdata_a,
   output logic [XLEN-1:0]       rdata_b
);

   localparam int AW = $clog2(NR_REG);

   logic [XLEN-1:0] regs [NR_REG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR_REG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0) && reg_in_range(waddr, NR_REG)) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if ((raddr_a != '0) && reg_in_range(raddr_a, NR_REG)) begin
         rdata_a = regs[raddr_a[AW-1:0]];
      end
      if ((raddr_b != '0) && reg_in_range(raddr_b, NR_REG)) begin
         rdata_b = regs[raddr_b[AW-1:0]];
      end
   end

endmodule

// File: rtl/wbu_pipe.sv
// Write-back stage: one-entry buffer between LSU and register file, with
// commit gating, rd bypass to decode, illegal-rd detection and instret.
module wbu_pipe
   import wbu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NR_REG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_lsu_rdata,
   input  logic [XLEN-1:0] in_csr_rdata,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_rd_wen,
   input  logic [4:0]      in_rd_addr,
   input  rd_sel_t         in_rd_sel,
   input  logic            commit_en,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_pc,
   output logic            wb_rd_err,
   output logic [63:0]     instret
);

   function automatic logic [XLEN-1:0] select_rd_data(
      input rd_sel_t         sel,
      input logic [XLEN-1:0] alu,
      input logic [XLEN-1:0] lsu,
      input logic [XLEN-1:0] csr,
      input logic [XLEN-1:0] pc
   );
      case (sel)
         RD_SEL_ALU: return alu;
         RD_SEL_LSU: return lsu;
         RD_SEL_CSR: return csr;
         default:    return pc + XLEN'(4);
      endcase
   endfunction

   logic            ent_valid;
   logic            ent_rd_wen;
   logic [4:0]      ent_rd_addr;
   rd_sel_t         ent_rd_sel;
   logic [XLEN-1:0] ent_alu_result;
   logic [XLEN-1:0] ent_lsu_rdata;
   logic [XLEN-1:0] ent_csr_rdata;
   logic [XLEN-1:0] ent_pc;
   logic [63:0]     instret_q;

   logic            accept;
   logic            commit;
   logic            rd_in_range;
   logic            rd_writes;
   logic            rf_we;
   logic [XLEN-1:0] rd_data;
   logic [XLEN-1:0] rf_rdata_a;
   logic [XLEN-1:0] rf_rdata_b;

   assign in_ready = !ent_valid || commit_en;
   assign accept   = in_valid && in_ready;
   assign commit   = ent_valid && commit_en;

   assign rd_data     = select_rd_data(ent_rd_sel, ent_alu_result, ent_lsu_rdata,
                                       ent_csr_rdata, ent_pc);
   assign rd_in_range = reg_in_range(ent_rd_addr, NR_REG);
   // A pending write that will really land in the file; drives both write and bypass.
   assign rd_writes   = ent_valid && ent_rd_wen && (ent_rd_addr != '0) && rd_in_range;
   assign rf_we       = rd_writes && commit_en;

   assign wb_valid  = commit;
   assign wb_pc     = ent_pc;
   assign wb_rd_err = commit && ent_rd_wen && !rd_in_range;
   assign instret   = instret_q;

   // Entry control: occupancy and retire count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= 1'b0;
         instret_q <= '0;
      end else begin
         if (accept) begin
            ent_valid <= 1'b1;
         end else if (commit) begin
            ent_valid <= 1'b0;
         end
         if (commit) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   // Entry payload: loads only on transfer, so it stays frozen while stalled
   always_ff @(posedge clk) begin
      if (accept) begin
         ent_rd_wen     <= in_rd_wen;
         ent_rd_addr    <= in_rd_addr;
         ent_rd_sel     <= in_rd_sel;
         ent_alu_result <= in_alu_result;
         ent_lsu_rdata  <= in_lsu_rdata;
         ent_csr_rdata  <= in_csr_rdata;
         ent_pc         <= in_pc;
      end
   end

   regfile_nr #(
      .XLEN   (XLEN),
      .NR_REG (NR_REG)
   ) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (ent_rd_addr),
      .wdata   (rd_data),
      .raddr_a (rs1_addr),
      .raddr_b (rs2_addr),
      .rdata_a (rf_rdata_a),
      .rdata_b (rf_rdata_b)
   );

   // Decode sees the pending result even while the commit is held off.
   always_comb begin
      rs1_data = rf_rdata_a;
      rs2_data = rf_rdata_b;
      if (rd_writes && (rs1_addr == ent_rd_addr)) begin
         rs1_data = rd_data;
      end
      if (rd_writes && (rs2_addr == ent_rd_addr)) begin
         rs2_data = rd_data;
      end
   end

endmodule

// File: tb/tb_wbu_pipe.sv
// Bench for wbu_pipe: an RV32I (32 regs) and an RV32E (16 regs) instance share
// stimulus and are checked against an instruction-level reference model.
module tb_wbu_pipe;
   import wbu_pkg::*;

   typedef struct {
      logic        wen;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] lsu;
      logic [31:0] csr;
      logic [31:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_alu_result, in_lsu_rdata, in_csr_rdata, in_pc;
   logic        in_rd_wen;
   logic [4:0]  in_rd_addr;
   rd_sel_t     in_rd_sel;
   logic        commit_en;
   logic [4:0]  rs1_addr, rs2_addr;

   logic        rdy  [2];
   logic [31:0] rs1d [2];
   logic [31:0] rs2d [2];
   logic        wbv  [2];
   logic [31:0] wbpc [2];
   logic        err  [2];
   logic [63:0] inst [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = 32 registers, index 1 = 16 registers
   logic [31:0] m_regs [2][32];
   logic [63:0] m_inst [2];
   bit          m_v    [2];
   ent_t        m_e    [2];

   always #5 clk = ~clk;

   wbu_pipe #(.XLEN(32), .NR_REG(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_alu_result(in_alu_result), .in_lsu_rdata(in_lsu_rdata),
      .in_csr_rdata(in_csr_rdata), .in_pc(in_pc), .in_rd_wen(in_rd_wen),
      .in_rd_addr(in_rd_addr), .in_rd_sel(in_rd_sel), .commit_en(commit_en),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1d[0]), .rs2_data(rs2d[0]),
      .wb_valid(wbv[0]), .wb_pc(wbpc[0]), .wb_rd_err(err[0]), .instret(inst[0])
   );

   wbu_pipe #(.XLEN(32), .NR_REG(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_alu_result(in_alu_result), .in_lsu_rdata(in_lsu_rdata),
      .in_csr_rdata(in_csr_rdata), .in_pc(in_pc), .in_rd_wen(in_rd_wen),
      .in_rd_addr(in_rd_addr), .in_rd_sel(in_rd_sel), .commit_en(commit_en),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1d[1]), .rs2_data(rs2d[1]),
      .wb_valid(wbv[1]), .wb_pc(wbpc[1]), .wb_rd_err(err[1]), .instret(inst[1])
   );

   function automatic int nr_of(input int k);
      return (k == 0) ? 32 : 16;
   endfunction

   function automatic logic [31:0] ent_value(input ent_t e);
      case (e.sel)
         2'd0:    return e.alu;
         2'd1:    return e.lsu;
         2'd2:    return e.csr;
         default: return e.pc + 32'd4;
      endcase
   endfunction

   // What decode should read: committed state plus the not-yet-committed result.
   function automatic logic [31:0] exp_rs(input int k, input logic [4:0] a);
      if (a == 5'd0 || int'(a) >= nr_of(k)) return 32'd0;
      if (m_v[k] && m_e[k].wen && m_e[k].rd == a) return ent_value(m_e[k]);
      return m_regs[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_v[k] = 1'b0;
         m_inst[k] = 64'd0;
         for (int r = 0; r < 32; r++) m_regs[k][r] = 32'd0;
      end
   endtask

   task automatic set_instr(input logic wen, input logic [4:0] rd, input rd_sel_t sel,
                            input logic [31:0] alu, input logic [31:0] pc);
      in_rd_wen     = wen;
      in_rd_addr    = rd;
      in_rd_sel     = sel;
      in_alu_result = alu;
      in_lsu_rdata  = $urandom;
      in_csr_rdata  = $urandom;
      in_pc         = pc;
   endtask

   // Advance one clock: update the model from the current inputs, then move to the next falling edge.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         bit acc, com;
         acc = in_valid && (!m_v[k] || commit_en);
         com = m_v[k] && commit_en;
         if (com) begin
            if (m_e[k].wen && m_e[k].rd != 5'd0 && int'(m_e[k].rd) < nr_of(k))
               m_regs[k][m_e[k].rd] = ent_value(m_e[k]);
            m_inst[k] = m_inst[k] + 64'd1;
         end
         if (acc) begin
            m_v[k] = 1'b1;
            m_e[k].wen = in_rd_wen;
            m_e[k].rd  = in_rd_addr;
            m_e[k].sel = in_rd_sel;
            m_e[k].alu = in_alu_result;
            m_e[k].lsu = in_lsu_rdata;
            m_e[k].csr = in_csr_rdata;
            m_e[k].pc  = in_pc;
         end else if (com) begin
            m_v[k] = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      commit_en = 1'b0;
      set_instr(1'b0, 5'd0, RD_SEL_ALU, 32'd0, 32'd0);
      rs1_addr = 5'd5;
      rs2_addr = 5'd31;
      model_reset();
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", k, rdy[k]); end
         n_tests++; if (wbv[k] !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid[%0d] got %b want 0", k, wbv[k]); end
         n_tests++; if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err[%0d] got %b want 0", k, err[k]); end
         n_tests++; if (inst[k] !== 64'd0) begin n_fail++; $display("FAIL reset_instret[%0d] got %0d want 0", k, inst[k]); end
         n_tests++; if (rs1d[k] !== 32'd0) begin n_fail++; $display("FAIL reset_rs1[%0d] got %h want 0", k, rs1d[k]); end
         n_tests++; if (rs2d[k] !== 32'd0) begin n_fail++; $display("FAIL reset_rs2[%0d] got %h want 0", k, rs2d[k]); end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      commit_en = 1'b1;
      in_valid = 1'b1;
      set_instr(1'b1, 5'd5, RD_SEL_ALU, 32'h0000_1234, 32'h0000_0100);
      #1;
      n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", rdy[0]); end
      tick();
      in_valid = 1'b0;
      rs1_addr = 5'd5;
      #1;
      n_tests++; if (wbv[0] !== 1'b1) begin n_fail++; $display("FAIL basic_wb_valid got %b want 1", wbv[0]); end
      n_tests++; if (wbpc[0] !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_wb_pc got %h want 00000100", wbpc[0]); end
      n_tests++; if (rs1d[0] !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_bypass got %h want 00001234", rs1d[0]); end
      tick();
      #1;
      n_tests++; if (wbv[0] !== 1'b0) begin n_fail++; $display("FAIL basic_wb_valid_after got %b want 0", wbv[0]); end
      n_tests++; if (rs1d[0] !== 32'h0000_1234) begin n_fail++; $display("FAIL basic_rf_read got %h want 00001234", rs1d[0]); end
      n_tests++; if (inst[0] !== 64'd1) begin n_fail++; $display("FAIL basic_instret got %0d want 1", inst[0]); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] base;
      int seen;
      base = m_inst[0];
      seen = 0;
      commit_en = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_instr(1'b1, 5'(10 + i), rd_sel_t'($urandom_range(0, 3)), $urandom, 32'h200 + 32'(4 * i));
         #1;
         if (wbv[0] === 1'b1) seen++;
         if (i > 0) begin
            n_tests++; if (wbpc[0] !== m_e[0].pc) begin n_fail++; $display("FAIL b2b_wb_pc[%0d] got %h want %h", i, wbpc[0], m_e[0].pc); end
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      if (wbv[0] === 1'b1) seen++;
      tick();
      #1;
      n_tests++; if (seen !== 4) begin n_fail++; $display("FAIL b2b_retire_cycles got %0d want 4", seen); end
      n_tests++; if (wbv[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", wbv[0]); end
      n_tests++; if (inst[0] !== base + 64'd4) begin n_fail++; $display("FAIL b2b_instret got %0d want %0d", inst[0], base + 64'd4); end
      for (int i = 0; i < 4; i++) begin
         rs1_addr = 5'(10 + i);
         #1;
         n_tests++; if (rs1d[0] !== exp_rs(0, rs1_addr)) begin n_fail++; $display("FAIL b2b_reg x%0d got %h want %h", rs1_addr, rs1d[0], exp_rs(0, rs1_addr)); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] old7;
      logic [63:0] base;
      old7 = m_regs[0][7];
      base = m_inst[0];
      commit_en = 1'b0;
      in_valid = 1'b1;
      set_instr(1'b1, 5'd7, RD_SEL_LINK, 32'h5555_5555, 32'h8000_0000);
      tick();
      set_instr(1'b1, 5'd9, RD_SEL_ALU, 32'h0000_ABCD, 32'h8000_0010);
      rs1_addr = 5'd9;
      rs2_addr = 5'd7;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", c, rdy[0]); end
         n_tests++; if (wbv[0] !== 1'b0) begin n_fail++; $display("FAIL stall_wb_valid[%0d] got %b want 0", c, wbv[0]); end
         n_tests++; if (rs2d[0] !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_bypass[%0d] got %h want 80000004", c, rs2d[0]); end
         n_tests++; if (rs1d[0] !== exp_rs(0, 5'd9)) begin n_fail++; $display("FAIL stall_rs1[%0d] got %h want %h", c, rs1d[0], exp_rs(0, 5'd9)); end
         n_tests++; if (dut32.u_rf.regs[7] !== old7) begin n_fail++; $display("FAIL stall_rf_x7[%0d] got %h want %h", c, dut32.u_rf.regs[7], old7); end
         n_tests++; if (inst[0] !== base) begin n_fail++; $display("FAIL stall_instret[%0d] got %0d want %0d", c, inst[0], base); end
         tick();
      end
      commit_en = 1'b1;
      #1;
      n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", rdy[0]); end
      n_tests++; if (wbv[0] !== 1'b1) begin n_fail++; $display("FAIL release_wb_valid got %b want 1", wbv[0]); end
      n_tests++; if (wbpc[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL release_wb_pc got %h want 80000000", wbpc[0]); end
      tick();
      in_valid = 1'b0;
      #1;
      n_tests++; if (dut32.u_rf.regs[7] !== 32'h8000_0004) begin n_fail++; $display("FAIL release_rf_x7 got %h want 80000004", dut32.u_rf.regs[7]); end
      n_tests++; if (inst[0] !== base + 64'd1) begin n_fail++; $display("FAIL release_instret got %0d want %0d", inst[0], base + 64'd1); end
      n_tests++; if (wbpc[0] !== 32'h8000_0010) begin n_fail++; $display("FAIL next_wb_pc got %h want 80000010", wbpc[0]); end
      n_tests++; if (rs1d[0] !== 32'h0000_ABCD) begin n_fail++; $display("FAIL next_bypass got %h want 0000abcd", rs1d[0]); end
      tick();
   endtask

   task automatic test_range();
      logic [31:0] val;
      logic [63:0] base1;
      val = $urandom | 32'h1;
      base1 = m_inst[1];
      commit_en = 1'b1;
      in_valid = 1'b1;
      set_instr(1'b1, 5'd20, RD_SEL_ALU, val, 32'h0000_0400);
      tick();
      in_valid = 1'b0;
      rs1_addr = 5'd20;
      #1;
      n_tests++; if (err[1] !== 1'b1) begin n_fail++; $display("FAIL rv32e_rd_err got %b want 1", err[1]); end
      n_tests++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rv32i_rd_err got %b want 0", err[0]); end
      n_tests++; if (rs1d[1] !== 32'd0) begin n_fail++; $display("FAIL rv32e_x20_bypass got %h want 0", rs1d[1]); end
      n_tests++; if (rs1d[0] !== val) begin n_fail++; $display("FAIL rv32i_x20_bypass got %h want %h", rs1d[0], val); end
      tick();
      #1;
      n_tests++; if (err[1] !== 1'b0) begin n_fail++; $display("FAIL rv32e_rd_err_pulse got %b want 0", err[1]); end
      n_tests++; if (rs1d[1] !== 32'd0) begin n_fail++; $display("FAIL rv32e_x20_read got %h want 0", rs1d[1]); end
      n_tests++; if (inst[1] !== base1 + 64'd1) begin n_fail++; $display("FAIL rv32e_instret got %0d want %0d", inst[1], base1 + 64'd1); end
      n_tests++; if (rs1d[0] !== val) begin n_fail++; $display("FAIL rv32i_x20_read got %h want %h", rs1d[0], val); end
      in_valid = 1'b1;
      set_instr(1'b1, 5'd0, RD_SEL_ALU, 32'h0000_FFFF, 32'h0000_0500);
      tick();
      in_valid = 1'b0;
      rs1_addr = 5'd0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (rs1d[k] !== 32'd0) begin n_fail++; $display("FAIL x0_bypass[%0d] got %h want 0", k, rs1d[k]); end
         n_tests++; if (err[k] !== 1'b0) begin n_fail++; $display("FAIL x0_rd_err[%0d] got %b want 0", k, err[k]); end
      end
      tick();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (rs1d[k] !== 32'd0) begin n_fail++; $display("FAIL x0_read[%0d] got %h want 0", k, rs1d[k]); end
      end
   endtask

   task automatic test_midreset();
      commit_en = 1'b0;
      in_valid = 1'b1;
      set_instr(1'b1, 5'd3, RD_SEL_ALU, $urandom, 32'h0000_0600);
      tick();
      in_valid = 1'b0;
      #1;
      n_tests++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_held_ready got %b want 0", rdy[0]); end
      #2;
      rst = 1'b1;
      commit_en = 1'b1;
      model_reset();
      #1;
      n_tests++; if (dut32.ent_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ent_valid got %b want 0", dut32.ent_valid); end
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (rdy[k] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready[%0d] got %b want 1", k, rdy[k]); end
         n_tests++; if (wbv[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_wb_valid[%0d] got %b want 0", k, wbv[k]); end
         n_tests++; if (inst[k] !== 64'd0) begin n_fail++; $display("FAIL midrst_instret[%0d] got %0d want 0", k, inst[k]); end
      end
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         #1;
         n_tests++; if (rs1d[0] !== 32'd0 || rs2d[0] !== 32'd0) begin n_fail++; $display("FAIL midrst_regs x%0d got %h/%h want 0", a, rs1d[0], rs2d[0]); end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (wbv[0] !== 1'b0) begin n_fail++; $display("FAIL postrst_wb_valid got %b want 0", wbv[0]); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      commit_en = 1'b1;
      in_valid = 1'b1;
      set_instr(1'b1, 5'd4, RD_SEL_CSR, $urandom, 32'h0000_0700);
      tick();
      in_valid = 1'b0;
      force dut32.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      force dut16.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut32.instret_q;
      release dut16.instret_q;
      m_inst[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      m_inst[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      n_tests++; if (inst[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffffffffffff", inst[0]); end
      tick();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (inst[k] !== 64'd0) begin n_fail++; $display("FAIL wrap_instret[%0d] got %h want 0", k, inst[k]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         commit_en = ($urandom_range(0, 3) != 0);
         set_instr($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                   rd_sel_t'($urandom_range(0, 3)), $urandom, $urandom & 32'hFFFF_FFFC);
         rs1_addr = 5'($urandom_range(0, 31));
         rs2_addr = 5'($urandom_range(0, 31));
         #1;
         for (int k = 0; k < 2; k++) begin
            logic ev, er;
            ev = m_v[k] && commit_en;
            er = ev && m_e[k].wen && int'(m_e[k].rd) >= nr_of(k);
            n_tests++; if (rdy[k] !== (!m_v[k] || commit_en)) begin n_fail++; $display("FAIL rnd_ready[%0d] c%0d got %b want %b", k, c, rdy[k], !m_v[k] || commit_en); end
            n_tests++; if (wbv[k] !== ev) begin n_fail++; $display("FAIL rnd_wb_valid[%0d] c%0d got %b want %b", k, c, wbv[k], ev); end
            n_tests++; if (err[k] !== er) begin n_fail++; $display("FAIL rnd_rd_err[%0d] c%0d got %b want %b", k, c, err[k], er); end
            if (ev) begin
               n_tests++; if (wbpc[k] !== m_e[k].pc) begin n_fail++; $display("FAIL rnd_wb_pc[%0d] c%0d got %h want %h", k, c, wbpc[k], m_e[k].pc); end
            end
            n_tests++; if (rs1d[k] !== exp_rs(k, rs1_addr)) begin n_fail++; $display("FAIL rnd_rs1[%0d] c%0d x%0d got %h want %h", k, c, rs1_addr, rs1d[k], exp_rs(k, rs1_addr)); end
            n_tests++; if (rs2d[k] !== exp_rs(k, rs2_addr)) begin n_fail++; $display("FAIL rnd_rs2[%0d] c%0d x%0d got %h want %h", k, c, rs2_addr, rs2d[k], exp_rs(k, rs2_addr)); end
            n_tests++; if (inst[k] !== m_inst[k]) begin n_fail++; $display("FAIL rnd_instret[%0d] c%0d got %0d want %0d", k, c, inst[k], m_inst[k]); end
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_range();
      test_midreset();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wbu_pipe.md
WBU_PIPE -- requirements
Module: wbu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NR_REG, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the upstream (LSU) handshake.
REQ-006 SHALL have ports in_alu_result, in_lsu_rdata, in_csr_rdata and in_pc, each input XLEN, the write-back candidates and the instruction PC.
REQ-007 SHALL have ports in_rd_wen input 1, in_rd_addr input 5 and in_rd_sel input 2 (rd_sel_t).
REQ-008 SHALL have port commit_en  input  1  commit permission; 0 holds the entry (debug halt).
REQ-009 SHALL have ports rs1_addr and rs2_addr, each input 5, and rs1_data and rs2_data, each output XLEN, the decode read ports.
REQ-010 SHALL have ports wb_valid output 1, wb_pc output XLEN and wb_rd_err output 1, the retire pulse, PC of the retired instruction and the illegal-rd pulse.
REQ-011 SHALL have port instret  output 64  retired-instruction count.

Function
REQ-012 SHALL hold one entry register (ent_valid plus latched fields); transfer occurs when in_valid && in_ready.
REQ-013 SHALL drive in_ready = !ent_valid || commit_en (combinational).
REQ-014 SHALL commit the entry on any edge where ent_valid && commit_en; latency is accept edge to commit edge = 1 cycle minimum.
REQ-015 SHALL, on simultaneous commit and transfer, commit the old entry and load the new one on the same edge with no bubble (one retire per cycle).
REQ-016 SHALL select rd_data by ent_rd_sel: ALU=00 alu_result, LSU=01 lsu_rdata, CSR=10 csr_rdata, LINK=11 pc+4 (modulo 2^XLEN).
REQ-017 SHALL write rd_data to the register file on commit iff ent_rd_wen && rd_addr != 0 && rd_addr < NR_REG.
REQ-018 SHALL pulse wb_rd_err for the commit cycle when ent_rd_wen && rd_addr >= NR_REG; that write SHALL be suppressed, and retire SHALL still count.
REQ-019 SHALL read x0 and out-of-range addresses as 0.
REQ-020 SHALL bypass: when ent_valid && ent_rd_wen && rsN_addr == ent_rd_addr != 0 && the address is in range, rsN_data = rd_data, regardless of commit_en.
REQ-021 SHALL drive wb_valid = ent_valid && commit_en and wb_pc = ent_pc, both combinational, for that cycle only.
REQ-022 SHALL increment instret by 1 per commit, wrapping 2^64-1 to 0.
REQ-023 SHALL keep the entry fields stable while ent_valid && !commit_en.

Reset
REQ-024 SHALL, while rst is high, asynchronously clear ent_valid and instret to 0 and all registers to 0; wb_valid and wb_rd_err SHALL be 0, and in_ready SHALL be 1.
REQ-025 SHALL discard an entry held when rst asserts mid-operation, with no write and no count.

Structure
REQ-026 SHALL place typedef rd_sel_t (RD_SEL_ALU, RD_SEL_LSU, RD_SEL_CSR, RD_SEL_LINK) in shared package wbu_pkg.
REQ-027 SHALL implement the register file as sub-module regfile_nr (params XLEN, NR_REG; 1 write port, 2 async read ports, x0 = 0); bypass and range checks SHALL stay in wbu_pipe.

Verification
REQ-028 Bench SHALL cover: accept wen=1 rd=5 sel=ALU alu=0x1234 with commit_en=1 -> next cycle wb_valid=1, and afterwards rs1_addr=5 reads 0x1234 and instret=1.
REQ-029 Bench SHALL cover: back-to-back stream of 4 instructions, in_valid held high -> wb_valid high on 4 consecutive cycles and instret=4.
REQ-030 Bench SHALL cover: commit_en=0 with an entry rd=7 sel=LINK pc=0x80000000 -> in_ready=0, rs2_addr=7 bypasses 0x80000004 and the regfile is unchanged; after commit_en=1 -> write then retire.
REQ-031 Bench SHALL cover: NR_REG=16 with wen rd=20 -> wb_rd_err pulse, no write, rs1_addr=20 reads 0, instret+1; also wen rd=0 value 0xFFFF -> x0 reads 0.
REQ-032 Bench SHALL cover: rst asserted mid-clock while the entry is valid -> ent_valid=0 immediately, instret=0, all registers read 0, and no wb_valid.
REQ-033 Bench SHALL cover: instret preloaded by force to 2^64-1 plus one commit -> instret=0.
